apb_timer: RTL

APB responder peripheral implementing a 32-bit prescaled up-counter with auto-reload, sticky overflow flag and level interrupt. It sits on the APB bus as one PSELx slave and answers the bus master's SETUP/ACCESS transfers with programmable wait states. Its interrupt output feeds the CPU's interrupt input.

---
 rtl/apb_timer_pkg.sv | 21 ++
 rtl/apb_timer_core.sv | 61 ++++++
 rtl/apb_timer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register offsets, control-bit positions
// and the bus responder state encoding.
package apb_timer_pkg;

    localparam logic [2:0] TCR_OFS  = 3'd0;
    localparam logic [2:0] PSC_OFS  = 3'd1;
    localparam logic [2:0] ARR_OFS  = 3'd2;
    localparam logic [2:0] TCNT_OFS = 3'd3;
    localparam logic [2:0] TSR_OFS  = 3'd4;

    localparam int TCR_EN_BIT  = 0;
    localparam int TCR_CLR_BIT = 1;
    localparam int TCR_IE_BIT  = 2;
    localparam int TSR_OVF_BIT = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaled 32-bit up-counter with >= auto-reload compare and a sticky
// overflow flag whose set beats a simultaneous clear.
module apb_timer_core
    import apb_timer_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] psc,
    input  logic [31:0] arr,
    input  logic        ovf_clr,
    output logic [31:0] tcnt,
    output logic        ovf
);

    logic [31:0] psc_cnt_reg, psc_cnt_next;
    logic [31:0] tcnt_reg, tcnt_next;
    logic        ovf_reg, ovf_next;
    logic        tick;
    logic        wrap;

    always_comb begin
        tick         = en & ~clr & (psc_cnt_reg == psc);
        wrap         = 1'b0;
        psc_cnt_next = psc_cnt_reg;
        tcnt_next    = tcnt_reg;
        if (clr) begin
            psc_cnt_next = 32'd0;
            tcnt_next    = 32'd0;
        end else if (en) begin
            psc_cnt_next = tick ? 32'd0 : psc_cnt_reg + 32'd1;
            if (tick) begin
                // >= so that lowering ARR under the live count wraps at once
                if (tcnt_reg >= arr) begin
                    tcnt_next = 32'd0;
                    wrap      = 1'b1;
                end else begin
                    tcnt_next = tcnt_reg + 32'd1;
                end
            end
        end
        ovf_next = wrap ? 1'b1 : (ovf_clr ? 1'b0 : ovf_reg);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psc_cnt_reg <= 32'd0;
            tcnt_reg    <= 32'd0;
            ovf_reg     <= 1'b0;
        end else begin
            psc_cnt_reg <= psc_cnt_next;
            tcnt_reg    <= tcnt_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign tcnt = tcnt_reg;
    assign ovf  = ovf_reg;

endmodule

// File: rtl/apb_timer.sv
// APB responder with programmable wait states wrapping the timer core:
// bus FSM, register file and combinational read mux.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    apb_slv_state_e state_reg, state_next;
    logic [2:0]     wait_cnt_reg, wait_cnt_next;
    logic           tcr_en_reg, tcr_ie_reg;
    logic [31:0]    psc_reg, arr_reg;
    logic [2:0]     addr;
    logic           pready;
    logic           wr_en;
    logic           clr_pulse;
    logic           ovf_clr;
    logic [31:0]    tcnt;
    logic           ovf;
    logic [31:0]    rd_mux;
    logic           unused_paddr;

    assign addr         = PADDR[4:2];
    assign unused_paddr = ^{PADDR[31:5], PADDR[1:0]};

    assign pready    = (state_reg == ACCESS) & PENABLE & (wait_cnt_reg == WS);
    assign wr_en     = pready & PWRITE;
    assign clr_pulse = wr_en & (addr == TCR_OFS) & PWDATA[TCR_CLR_BIT];
    assign ovf_clr   = wr_en & (addr == TSR_OFS) & PWDATA[TSR_OVF_BIT];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        if (!PSEL) begin
            state_next    = IDLE;
            wait_cnt_next = 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!PENABLE) begin
                        state_next    = ACCESS;
                        wait_cnt_next = 3'd0;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        state_next    = IDLE;
                        wait_cnt_next = 3'd0;
                    end else if (wait_cnt_reg != WS) begin
                        wait_cnt_next = wait_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    wait_cnt_next = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Registers only change on the edge that completes a write transfer
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tcr_en_reg <= 1'b0;
            tcr_ie_reg <= 1'b0;
            psc_reg    <= 32'd0;
            arr_reg    <= 32'hFFFF_FFFF;
        end else if (wr_en) begin
            case (addr)
                TCR_OFS: begin
                    tcr_en_reg <= PWDATA[TCR_EN_BIT];
                    tcr_ie_reg <= PWDATA[TCR_IE_BIT];
                end
                PSC_OFS: psc_reg <= PWDATA;
                ARR_OFS: arr_reg <= PWDATA;
                default: ;
            endcase
        end
    end

    apb_timer_core u_core (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .en      (tcr_en_reg),
        .clr     (clr_pulse),
        .psc     (psc_reg),
        .arr     (arr_reg),
        .ovf_clr (ovf_clr),
        .tcnt    (tcnt),
        .ovf     (ovf)
    );

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            TCR_OFS:  rd_mux = {29'd0, tcr_ie_reg, 1'b0, tcr_en_reg};
            PSC_OFS:  rd_mux = psc_reg;
            ARR_OFS:  rd_mux = arr_reg;
            TCNT_OFS: rd_mux = tcnt;
            TSR_OFS:  rd_mux = {31'd0, ovf};
            default:  rd_mux = 32'd0;
        endcase
    end

    assign PRDATA = pready ? rd_mux : 32'd0;
    assign PREADY = pready;
    assign irq    = ovf & tcr_ie_reg;

endmodule
